// File: rtl/igpu_stream.sv
// igpu_stream: stallable header/residual/compress tile pipeline feeding a
// commit-record FIFO and a multi-line valid/ready serialiser.

package types;
  localparam int PX_N = 64;

  typedef logic [PX_N-1:0][7:0] px_vec_t;

  typedef struct packed {
    logic [1:0] flag;
    px_vec_t    px;
  } pixels_t;

  typedef struct packed {
    logic [1:0] flag;
    logic [7:0] base;
    px_vec_t    px;
  } hdr_t;

  typedef struct packed {
    logic [1:0] flag;
    px_vec_t    res;
  } res_t;

  // Header stage: the first pixel of the tile becomes the prediction base.
  function automatic hdr_t header(input pixels_t p);
    hdr_t h;
    h.flag = p.flag;
    h.base = p.px[0];
    h.px   = p.px;
    return h;
  endfunction

  function automatic res_t residual(input hdr_t h);
    res_t r;
    r.flag = h.flag;
    for (int i = 0; i < PX_N; i++) r.res[i] = h.px[i] - h.base;
    return r;
  endfunction
endpackage

module igpu_stream #(
  parameter  int LINE_W     = 512,
  parameter  int MAX_LINES  = 2,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CNT_W      = 32,
  localparam int IDX_W      = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  types::pixels_t       pixels,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LINE_W-1:0]    out_line,
  output logic [1:0]           out_flag,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     tile_cnt,
  output logic [CNT_W-1:0]     line_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0]                         flag;
    logic [MAX_LINES-1:0][LINE_W-1:0]   lines;
  } rec_t;

  // Compress stage: line j carries the residual vector offset by j.
  function automatic rec_t compress(input types::res_t r);
    rec_t c;
    c.flag = r.flag;
    for (int j = 0; j < MAX_LINES; j++) c.lines[j] = LINE_W'(r.res) + LINE_W'(j);
    return c;
  endfunction

  types::hdr_t s1;
  types::res_t s2;
  rec_t        s3;
  logic        v1, v2, v3;
  logic        adv1, adv2, adv3, accept;

  rec_t           mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           fifo_full, fifo_empty, push, pop;

  rec_t             head;
  logic [IDX_W-1:0] idx;
  int               n_lines;
  logic             last, line_acc;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  assign adv3     = v3 & ~fifo_full;
  assign adv2     = v2 & (~v3 | adv3);
  assign adv1     = v1 & (~v2 | adv2);
  assign in_ready = ~v1 | adv1;
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (accept)    v1 <= 1'b1;
      else if (adv1) v1 <= 1'b0;
      if (adv1)      v2 <= 1'b1;
      else if (adv2) v2 <= 1'b0;
      if (adv2)      v3 <= 1'b1;
      else if (adv3) v3 <= 1'b0;
    end
  end

  // NOTE: payload registers and FIFO storage carry no reset; the valid bits
  // and the FIFO count alone decide whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (accept) s1 <= types::header(pixels);
    if (adv1)   s2 <= types::residual(s1);
    if (adv2)   s3 <= compress(s2);
    if (push)   mem[wr_ptr] <= s3;
  end

  assign push = adv3;
  assign pop  = line_acc & last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    n_lines = MAX_LINES;
    if (head.flag != 2'd0 && int'(head.flag) < MAX_LINES) n_lines = int'(head.flag);
  end

  assign last     = (int'(idx) == n_lines - 1);
  assign out_valid = ~fifo_empty;
  assign line_acc = out_valid & out_ready;

  assign out_line = out_valid ? head.lines[idx] : '0;
  assign out_flag = out_valid ? head.flag : 2'd0;
  assign out_last = out_valid & last;
  assign out_idx  = idx;
  assign busy     = v1 | v2 | v3 | ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      tile_cnt <= '0;
      line_cnt <= '0;
    end else if (line_acc) begin
      idx      <= last ? '0 : idx + 1'b1;
      line_cnt <= line_cnt + 1'b1;
      if (last) tile_cnt <= tile_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_igpu_stream.sv
// Directed bench for igpu_stream: latency, ordering, backpressure, async reset
// and statistics counter wrap, with a line scoreboard built from tile recipes.
`timescale 1ns/1ps
module tb_igpu_stream;
  import types::*;

  localparam int LINE_W = 512;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, out_last, busy;
  pixels_t           pixels;
  logic [LINE_W-1:0] out_line;
  logic [1:0]        out_flag;
  logic [0:0]        out_idx;
  logic [CNT_W-1:0]  tile_cnt, line_cnt;

  logic              w_in_valid, w_in_ready, w_out_valid, w_out_last, w_busy;
  pixels_t           w_pixels;
  logic [LINE_W-1:0] w_out_line;
  logic [1:0]        w_out_flag;
  logic [0:0]        w_out_idx;
  logic [3:0]        w_tile_cnt, w_line_cnt;

  typedef struct {
    logic [LINE_W-1:0] line;
    logic [1:0]        flag;
    logic              idx;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  igpu_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pixels(pixels),
    .out_valid(out_valid), .out_ready(out_ready), .out_line(out_line), .out_flag(out_flag),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .tile_cnt(tile_cnt), .line_cnt(line_cnt)
  );

  igpu_stream #(.CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .pixels(w_pixels),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_line(w_out_line), .out_flag(w_out_flag),
    .out_idx(w_out_idx), .out_last(w_out_last), .busy(w_busy), .tile_cnt(w_tile_cnt),
    .line_cnt(w_line_cnt)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Tile t is built from a chosen residual vector; px[0] is the base so its residual is 0.
  function automatic logic [LINE_W-1:0] line0_of(input int t);
    px_vec_t d;
    d = '0;
    for (int i = 1; i < PX_N; i++) d[i] = 8'(i * (t + 1) + t);
    return LINE_W'(d);
  endfunction

  function automatic pixels_t tile_of(input int t, input logic [1:0] f);
    pixels_t    p;
    px_vec_t    d;
    logic [7:0] base;
    d      = line0_of(t);
    base   = 8'(8'h10 + 7 * t);
    p.flag = f;
    for (int i = 0; i < PX_N; i++) p.px[i] = base + d[i];
    return p;
  endfunction

  function automatic int lines_of(input logic [1:0] f);
    case (f)
      2'd1:    return 1;
      default: return 2;
    endcase
  endfunction

  task automatic push_exp(input int t, input logic [1:0] f);
    int n;
    n = lines_of(f);
    for (int j = 0; j < n; j++)
      sb.push_back('{line0_of(t) + LINE_W'(j), f, 1'(j), (j == n - 1)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int t, input logic [1:0] f, output bit acc);
    in_valid = 1'b1;
    pixels   = tile_of(t, f);
    acc      = in_ready;
    if (acc) push_exp(t, f);
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int c;
    c = 0;
    while (!out_valid && c < budget) begin
      tick();
      c++;
    end
    check(tag, out_valid, 1'b1);
  endtask

  task automatic wait_wrap_idle(input string tag);
    int c;
    c = 0;
    while (w_busy && c < 100) begin
      tick();
      c++;
    end
    check(tag, w_busy, 1'b0);
  endtask

  // Output monitor: scoreboard on every accepted line, hold check while stalled.
  initial begin
    logic [LINE_W-1:0] held_line;
    logic [1:0]        held_flag;
    logic              held_idx, held_last;
    bit                prev_stall;
    exp_t              e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall && out_valid) begin
        check("hold_line", out_line, held_line);
        check("hold_flag", out_flag, held_flag);
        check("hold_idx", out_idx, held_idx);
        check("hold_last", out_last, held_last);
      end
      prev_stall = out_valid && !out_ready && !rst;
      held_line  = out_line;
      held_flag  = out_flag;
      held_idx   = out_idx;
      held_last  = out_last;
      if (out_valid && out_ready) begin
        check("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("line_data", out_line, e.line);
          check("line_flag", out_flag, e.flag);
          check("line_idx", out_idx, e.idx);
          check("line_last", out_last, e.last);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bit               acc;
    int               k, cyc;
    logic [CNT_W-1:0] l0, t0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pixels = '0;
    w_in_valid = 1'b0; w_pixels = '0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_line", out_line, '0);
    check("rst_out_flag", out_flag, 2'd0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_tile_cnt", tile_cnt, '0);
    check("rst_line_cnt", line_cnt, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single one-line tile: out_valid appears three edges after the accept edge.
    out_ready = 1'b1;
    present(0, 2'd1, acc);
    check("t1_accept", acc, 1'b1);
    in_valid = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      check($sformatf("t1_latency_%0d", c), out_valid, (c == 3));
      if (c < 3) tick();
    end
    check("t1_idx", out_idx, 1'b0);
    check("t1_last", out_last, 1'b1);
    check("t1_flag", out_flag, 2'd1);
    check("t1_line", out_line, line0_of(0));
    tick();
    check("t1_tile_cnt", tile_cnt, 1);
    check("t1_line_cnt", line_cnt, 1);
    check("t1_busy", busy, 1'b0);

    // Eight back-to-back two-line tiles.
    t0 = tile_cnt; l0 = line_cnt;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 200) begin
      present(10 + k, 2'd0, acc);
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    check("t2_accepted", k, 8);
    wait_idle("t2_drain", 200);
    check("t2_tiles", tile_cnt - t0, 8);
    check("t2_lines", line_cnt - l0, 16);
    check("t2_sb_empty", sb.size(), 0);

    // Sink stalled for 20 cycles: pipe + FIFO absorb exactly 7 tiles.
    out_ready = 1'b0;
    t0 = tile_cnt; l0 = line_cnt;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      present(20 + k, 2'((k % 3) + 1), acc);
      if (acc) k++;
    end
    check("t3_accepted", k, 7);
    check("t3_in_ready_low", in_ready, 1'b0);
    check("t3_out_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("t3_drain", 200);
    check("t3_tiles", tile_cnt - t0, 7);
    check("t3_lines", line_cnt - l0, 11);
    check("t3_sb_empty", sb.size(), 0);

    // Random sink backpressure with a continuous source, all flag values.
    k = 0; cyc = 0;
    while (k < 12 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      present(40 + k, 2'(k % 4), acc);
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    check("t4_accepted", k, 12);
    out_ready = 1'b1;
    wait_idle("t4_drain", 300);
    check("t4_sb_empty", sb.size(), 0);

    // Asynchronous reset after line 0 of a two-line tile.
    out_ready = 1'b0;
    present(60, 2'd0, acc);
    check("t5_accept", acc, 1'b1);
    in_valid = 1'b0;
    wait_out_valid("t5_first_valid", 10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_mid_tile_idx", out_idx, 1'b1);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("t5_rst_out_valid", out_valid, 1'b0);
    check("t5_rst_tile_cnt", tile_cnt, '0);
    check("t5_rst_line_cnt", line_cnt, '0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_in_ready", in_ready, 1'b1);
    check("t5_rst_out_line", out_line, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    present(61, 2'd1, acc);
    in_valid = 1'b0;
    wait_out_valid("t5_next_valid", 10);
    check("t5_next_idx", out_idx, 1'b0);
    check("t5_next_line", out_line, line0_of(61));
    out_ready = 1'b1;
    wait_idle("t5_drain", 20);
    check("t5_tile_cnt", tile_cnt, 1);

    // Four-bit counters: 15 tiles reach the maximum, the 16th wraps to zero.
    k = 0; cyc = 0;
    while (k < 15 && cyc < 100) begin
      w_in_valid = 1'b1;
      w_pixels   = tile_of(80 + k, 2'd1);
      if (w_in_ready) k++;
      tick();
      cyc++;
    end
    w_in_valid = 1'b0;
    wait_wrap_idle("t6_drain_a");
    check("t6_tile_cnt_max", w_tile_cnt, 4'hF);
    check("t6_line_cnt_max", w_line_cnt, 4'hF);
    w_in_valid = 1'b1;
    w_pixels   = tile_of(95, 2'd1);
    check("t6_ready", w_in_ready, 1'b1);
    tick();
    w_in_valid = 1'b0;
    wait_wrap_idle("t6_drain_b");
    check("t6_tile_cnt_wrap", w_tile_cnt, 4'h0);
    check("t6_line_cnt_wrap", w_line_cnt, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
